cache_arbiter: RTL and testbench

Arbitrates the I-cache and D-cache physical-memory miss ports onto the single cacheline memory port of the mp3 core. It sits between the two caches and the cacheline adaptor that drives the burst memory interface. Each granted transaction is one 256-bit line read or write. Two counters track completed transactions per cache so the bench can sample miss traffic.

---
 rtl/cache_arbiter.sv | 133 +++++++++++++
 tb/tb_cache_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one cacheline memory port.
// Build option CACHE_ARBITER_RR_EN: round-robin on ties; otherwise D always wins a tie.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_pmem_address,
  input  logic         i_pmem_read,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic [31:0]  d_pmem_address,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp,
  output logic [31:0]  perf_i_count,
  output logic [31:0]  perf_d_count
);

  // Handshake: a cache holds read/write (and address/wdata) high until it sees
  // its one-cycle resp; the adaptor answers a granted read/write with a
  // one-cycle mem_resp carrying mem_rdata. The state is the grant record.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        i_req;
  logic        d_req;
  logic        grant_d;
  logic        i_done;
  logic        d_done;
  logic [31:0] perf_i_q;
  logic [31:0] perf_d_q;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARBITER_RR_EN
  // Remembers who was granted most recently: 0 = I, 1 = D.
  logic last_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && (i_req || d_req)) begin
      last_grant_d <= grant_d;
    end
  end

  assign grant_d = d_req && (!i_req || !last_grant_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = D_BUSY;
        end else if (i_req) begin
          state_next = I_BUSY;
        end
      end
      I_BUSY: if (mem_resp) state_next = IDLE;
      D_BUSY: if (mem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_address = 32'h0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      I_BUSY: begin
        mem_address = i_pmem_address & 32'hFFFF_FFE0;
        mem_read    = 1'b1;
        i_pmem_resp = mem_resp;
      end
      D_BUSY: begin
        // Read and write are forwarded as-is, even if both are set.
        mem_address = d_pmem_address & 32'hFFFF_FFE0;
        mem_read    = d_pmem_read;
        mem_write   = d_pmem_write;
        mem_wdata   = d_pmem_wdata;
        d_pmem_resp = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  assign i_done = (state == I_BUSY) && mem_resp;
  assign d_done = (state == D_BUSY) && mem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_q <= 32'h0;
      perf_d_q <= 32'h0;
    end else begin
      if (i_done) perf_i_q <= perf_i_q + 32'd1;
      if (d_done) perf_d_q <= perf_d_q + 32'd1;
    end
  end

  assign perf_i_count = perf_i_q;
  assign perf_d_count = perf_d_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a vector table of single transactions,
// then tie rounds, spurious resp, reset abort and counter wrap sequences.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_read;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [31:0]  d_pmem_address;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  perf_i_count;
  logic [31:0]  perf_d_count;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .perf_i_count(perf_i_count), .perf_d_count(perf_d_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         i_read;
    logic         d_read;
    logic         d_write;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    logic [31:0]  exp_addr;
    logic         exp_read;
    logic         exp_write;
  } vec_t;

  typedef struct {
    logic raise_i;
    logic raise_d;
    logic exp_d;
  } round_t;

  vec_t        vecs[5];
  round_t      rounds[5];
  int          tests = 0;
  int          failed = 0;
  int          violations = 0;
  logic [31:0] exp_i_cnt = 0;
  logic [31:0] exp_d_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_pmem_address = 32'h0;
    i_pmem_read    = 1'b0;
    d_pmem_address = 32'h0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_wdata   = '0;
    mem_rdata      = '0;
    mem_resp       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_i_cnt = 0;
    exp_d_cnt = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " perf_i_count"}, 256'(perf_i_count), 256'(exp_i_cnt));
    check({tag, " perf_d_count"}, 256'(perf_d_count), 256'(exp_d_cnt));
  endtask

  // Entered and left at a negedge with the arbiter idle.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    i_pmem_read    = v.i_read;
    i_pmem_address = v.i_read ? v.addr : ~v.addr;
    d_pmem_read    = v.d_read;
    d_pmem_write   = v.d_write;
    d_pmem_address = v.i_read ? ~v.addr : v.addr;
    d_pmem_wdata   = v.wdata;
    if (v.d_read && v.d_write) begin
      violations++;
      $display("[TB] note: d-cache protocol violation (read and write together) in %s", tag);
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, " mem_address"}, 256'(mem_address), 256'(v.exp_addr));
    check({tag, " mem_read"}, 256'(mem_read), 256'(v.exp_read));
    check({tag, " mem_write"}, 256'(mem_write), 256'(v.exp_write));
    if (!v.i_read) check({tag, " mem_wdata"}, mem_wdata, v.wdata);
    check({tag, " resp before mem_resp"}, 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    mem_resp  = 1'b1;
    mem_rdata = v.rdata;
    #1;
    check({tag, " i_pmem_resp"}, 256'(i_pmem_resp), 256'(v.i_read));
    check({tag, " d_pmem_resp"}, 256'(d_pmem_resp), 256'(!v.i_read));
    if (v.i_read) check({tag, " i_pmem_rdata"}, i_pmem_rdata, v.rdata);
    else          check({tag, " d_pmem_rdata"}, d_pmem_rdata, v.rdata);
    if (v.i_read) exp_i_cnt++;
    else          exp_d_cnt++;
    @(posedge clk);
    @(negedge clk);
    mem_resp     = 1'b0;
    i_pmem_read  = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    #1;
    check({tag, " idle after resp"}, 256'({mem_read, mem_write, i_pmem_resp, d_pmem_resp}), 256'(0));
    check_counts(tag);
  endtask

  initial begin
    logic i_pend;
    logic d_pend;
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, '0, {32{8'hAB}}, 32'h0000_0040, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h1000_0020, {8{32'hDEAD_BEEF}}, '0, 32'h1000_0020, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_07FF, '0, {32{8'h55}}, 32'h0000_07E0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, '0, {8{32'h0123_4567}}, 32'hFFFF_FFE0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h3000_001F, {8{32'hC0FF_EE00}}, {32{8'h3C}}, 32'h3000_0000, 1'b1, 1'b1};

`ifdef CACHE_ARBITER_RR_EN
    rounds[0] = '{1'b1, 1'b1, 1'b1};
    rounds[1] = '{1'b0, 1'b0, 1'b0};
    rounds[2] = '{1'b0, 1'b1, 1'b1};
    rounds[3] = '{1'b1, 1'b1, 1'b0};
    rounds[4] = '{1'b0, 1'b0, 1'b1};
`else
    rounds[0] = '{1'b1, 1'b1, 1'b1};
    rounds[1] = '{1'b0, 1'b0, 1'b0};
    rounds[2] = '{1'b0, 1'b1, 1'b1};
    rounds[3] = '{1'b1, 1'b1, 1'b1};
    rounds[4] = '{1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 256'({mem_read, mem_write, i_pmem_resp, d_pmem_resp, mem_address}), 256'(0));
    check("reset mem_wdata", mem_wdata, '0);
    check("reset state", 256'(dut.state), 256'(0));
    check_counts("reset");
    rst = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Tie rounds: the served cache drops its request, pending ones stay held.
    do_reset();
    i_pend = 1'b0;
    d_pend = 1'b0;
    d_pmem_address = 32'h2000_0047;
    i_pmem_address = 32'h0000_1234;
    for (int r = 0; r < 5; r++) begin
      if (rounds[r].raise_i) i_pend = 1'b1;
      if (rounds[r].raise_d) d_pend = 1'b1;
      i_pmem_read = i_pend;
      d_pmem_read = d_pend;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("round%0d mem_address", r), 256'(mem_address),
            256'(rounds[r].exp_d ? 32'h2000_0040 : 32'h0000_1220));
      check($sformatf("round%0d mem_read", r), 256'(mem_read), 256'(1));
      mem_resp  = 1'b1;
      mem_rdata = {8{r[31:0]}};
      #1;
      check($sformatf("round%0d d_pmem_resp", r), 256'(d_pmem_resp), 256'(rounds[r].exp_d));
      check($sformatf("round%0d i_pmem_resp", r), 256'(i_pmem_resp), 256'(!rounds[r].exp_d));
      if (rounds[r].exp_d) begin
        exp_d_cnt++;
      end else begin
        exp_i_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      mem_resp = 1'b0;
      if (rounds[r].exp_d) d_pend = 1'b0;
      else                 i_pend = 1'b0;
      i_pmem_read = i_pend;
      d_pmem_read = d_pend;
      #1;
      check($sformatf("round%0d idle gap", r), 256'({mem_read, mem_write}), 256'(0));
      check_counts($sformatf("round%0d", r));
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;

    // Spurious mem_resp while idle
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    check("spurious resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    @(posedge clk);
    @(negedge clk);
    mem_resp = 1'b0;
    check("spurious state", 256'(dut.state), 256'(0));
    check_counts("spurious");

    // Reset while D_BUSY waits for the adaptor
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    check("abort pre mem_write", 256'(mem_write), 256'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    d_pmem_write = 1'b0;
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    #1;
    check("abort outputs", 256'({mem_read, mem_write, d_pmem_resp, i_pmem_resp}), 256'(0));
    check("abort state", 256'(dut.state), 256'(0));
    check_counts("abort");

    // Counter wrap on the I side
    @(negedge clk);
    force dut.perf_i_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.perf_i_q;
    exp_i_cnt = 32'hFFFF_FFFF;
    check_counts("wrap preload");
    run_vec(vecs[0], 10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
